// File: rtl/mfcc_fe_pkg.sv
// Shared state type, default frame geometry and window-address fold for the MFCC front end.
package mfcc_fe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    WAIT_BACK,
    DONE
  } seq_state_e;

  localparam int DEF_FRAME_LEN = 256;
  localparam int DEF_HOP       = 128;
  localparam int DEF_FFT_LEN   = 256;

  // The window is symmetric, so the ROM stores only the first half.
  // Slots in the second half mirror back onto it.
  function automatic int win_fold(input int idx, input int frame_len);
    return (idx < frame_len / 2) ? idx : frame_len - 1 - idx;
  endfunction

endpackage

// File: rtl/mfcc_seq_align.sv
// One-stage register bank that delays the issue-cycle qualifiers by the RAM read latency.
// Its outputs therefore line up with the sample data coming back from the RAM.
module mfcc_seq_align #(
  parameter int WIN_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_rd,
  input  logic             issue_new,
  input  logic [WIN_W-1:0] issue_win,
  input  logic             issue_pad,
  input  logic             issue_last,
  output logic             preemp_en,
  output logic             preemp_new,
  output logic [WIN_W-1:0] win_addr,
  output logic             win_en,
  output logic             zero_pad,
  output logic             last_sample
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      preemp_en   <= 1'b0;
      preemp_new  <= 1'b0;
      win_addr    <= '0;
      win_en      <= 1'b0;
      zero_pad    <= 1'b0;
      last_sample <= 1'b0;
    end else begin
      preemp_en   <= issue_rd;
      preemp_new  <= issue_new;
      win_addr    <= issue_win;
      win_en      <= issue_rd;
      zero_pad    <= issue_pad;
      last_sample <= issue_last;
    end
  end

endmodule

// File: rtl/mfcc_frame_sequencer.sv
// Overlapping-frame sequencer that drives sample RAM reads and pre-emphasis/window/FFT strobes.
// Define MFCC_SEQ_ZPAD_EN to pad each frame with zero slots up to FFT_LEN.
module mfcc_frame_sequencer
  import mfcc_fe_pkg::*;
#(
  parameter int  ADDR_W      = 15,
  parameter int  FRAME_LEN   = DEF_FRAME_LEN,
  parameter int  HOP         = DEF_HOP,
  parameter int  FFT_LEN     = DEF_FFT_LEN,
  parameter int  FRAME_CNT_W = 8,
  localparam int WIN_W       = $clog2(FRAME_LEN / 2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   ready,
  input  logic                   back_done,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_rd,
  output logic                   preemp_en,
  output logic                   preemp_new,
  output logic [WIN_W-1:0]       win_addr,
  output logic                   win_en,
  output logic                   zero_pad,
  output logic                   last_sample,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] framenum,
  output logic                   fefinish
);

`ifdef MFCC_SEQ_ZPAD_EN
  localparam int SLOTS = FFT_LEN;
  if (FFT_LEN < FRAME_LEN) begin : g_bad_fft_len
    $error("FFT_LEN must be >= FRAME_LEN");
  end
`else
  localparam int SLOTS = FRAME_LEN;
  if (FFT_LEN != FRAME_LEN) begin : g_bad_fft_len
    $error("FFT_LEN must equal FRAME_LEN when zero padding is disabled");
  end
`endif

  if (HOP < 1 || HOP > FRAME_LEN) begin : g_bad_hop
    $error("HOP must lie in 1..FRAME_LEN");
  end

  localparam int IDX_W = $clog2(SLOTS);

  seq_state_e             state;
  logic [IDX_W-1:0]       idx;
  logic [ADDR_W-1:0]      frame_base;
  logic [FRAME_CNT_W-1:0] nf_q;
  logic                   accept;
  logic                   in_frame;
  logic                   last_slot;
  logic                   issue_pad;
  logic [WIN_W-1:0]       issue_win;

  // A slot is consumed only when the FFT side is ready.
  // A stall therefore freezes idx and issues no strobe.
  assign accept    = (state == STREAM) && ready;
  assign in_frame  = int'(idx) < FRAME_LEN;
  assign last_slot = int'(idx) == SLOTS - 1;
  assign ram_rd    = accept && in_frame;
  assign ram_addr  = frame_base + ADDR_W'(idx);
  assign issue_win = ram_rd ? WIN_W'(win_fold(int'(idx), FRAME_LEN)) : '0;
  assign busy      = state inside {LOAD, STREAM, WAIT_BACK};
  assign fefinish  = (state == DONE);

`ifdef MFCC_SEQ_ZPAD_EN
  assign issue_pad = accept && !in_frame;
`else
  assign issue_pad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      frame_base <= '0;
      nf_q       <= '0;
      framenum   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          nf_q       <= num_frames;
          frame_base <= base_addr;
          framenum   <= '0;
          idx        <= '0;
          state      <= LOAD;
        end
        LOAD: state <= (nf_q == '0) ? DONE : STREAM;
        STREAM: if (ready) begin
          // SLOTS is a power of two, so idx wraps to 0 after the final slot.
          idx <= idx + 1'b1;
          if (last_slot) state <= WAIT_BACK;
        end
        WAIT_BACK: if (back_done) begin
          if (framenum == nf_q - 1'b1) begin
            state <= DONE;
          end else begin
            framenum   <= framenum + 1'b1;
            frame_base <= frame_base + ADDR_W'(HOP);
            idx        <= '0;
            state      <= STREAM;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mfcc_seq_align #(.WIN_W(WIN_W)) u_align (
    .clk         (clk),
    .rst         (rst),
    .issue_rd    (ram_rd),
    .issue_new   (ram_rd && idx == '0),
    .issue_win   (issue_win),
    .issue_pad   (issue_pad),
    .issue_last  (accept && last_slot),
    .preemp_en   (preemp_en),
    .preemp_new  (preemp_new),
    .win_addr    (win_addr),
    .win_en      (win_en),
    .zero_pad    (zero_pad),
    .last_sample (last_sample)
  );

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// Self-checking bench for mfcc_frame_sequencer: directed and random runs against a slot-level model.
// Expected addresses and strobes come from frame/slot arithmetic, one slot per accepted ready cycle.
module tb_mfcc_frame_sequencer;

  localparam int ADDR_W = 15;
  localparam int FL     = 8;
  localparam int HOP    = 4;
`ifdef MFCC_SEQ_ZPAD_EN
  localparam int FFT    = 16;
`else
  localparam int FFT    = 8;
`endif
  localparam int CNT_W  = 8;
  localparam int WIN_W  = 2;

  typedef struct packed {
    logic             rd;
    logic             nw;
    logic             pad;
    logic             last;
    logic [WIN_W-1:0] win;
  } slot_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  num_frames;
  logic [ADDR_W-1:0] base_addr;
  logic              ready;
  logic              back_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic              preemp_en;
  logic              preemp_new;
  logic [WIN_W-1:0]  win_addr;
  logic              win_en;
  logic              zero_pad;
  logic              last_sample;
  logic              busy;
  logic [CNT_W-1:0]  framenum;
  logic              fefinish;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mfcc_frame_sequencer #(
    .ADDR_W      (ADDR_W),
    .FRAME_LEN   (FL),
    .HOP         (HOP),
    .FFT_LEN     (FFT),
    .FRAME_CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_frames  (num_frames),
    .base_addr   (base_addr),
    .ready       (ready),
    .back_done   (back_done),
    .ram_addr    (ram_addr),
    .ram_rd      (ram_rd),
    .preemp_en   (preemp_en),
    .preemp_new  (preemp_new),
    .win_addr    (win_addr),
    .win_en      (win_en),
    .zero_pad    (zero_pad),
    .last_sample (last_sample),
    .busy        (busy),
    .framenum    (framenum),
    .fefinish    (fefinish)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the FFT path should see for slot s of a frame.
  function automatic slot_t slot_of(input int s);
    slot_t r;
    r      = '0;
    r.rd   = (s < FL);
    r.nw   = (s == 0);
    r.pad  = (s >= FL);
    r.last = (s == FFT - 1);
    if (s < FL / 2)  r.win = WIN_W'(s);
    else if (s < FL) r.win = WIN_W'(FL - 1 - s);
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] base, input int f, input int s);
    int a;
    a = (int'(base) + f * HOP + s) % (1 << ADDR_W);
    return ADDR_W'(a);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_aligned(input slot_t e, input string ctx);
    check({ctx, ":preemp_en"},   32'(preemp_en),   32'(e.rd));
    check({ctx, ":win_en"},      32'(win_en),      32'(e.rd));
    check({ctx, ":preemp_new"},  32'(preemp_new),  32'(e.nw && e.rd));
    check({ctx, ":zero_pad"},    32'(zero_pad),    32'(e.pad));
    check({ctx, ":last_sample"}, 32'(last_sample), 32'(e.last));
    if (e.rd) check({ctx, ":win_addr"}, 32'(win_addr), 32'(e.win));
  endtask

  task automatic check_quiet(input string ctx);
    check({ctx, ":ram_addr"}, 32'(ram_addr), 32'd0);
    check({ctx, ":ram_rd"},   32'(ram_rd),   32'd0);
    check({ctx, ":win_addr"}, 32'(win_addr), 32'd0);
    check({ctx, ":busy"},     32'(busy),     32'd0);
    check({ctx, ":framenum"}, 32'(framenum), 32'd0);
    check({ctx, ":fefinish"}, 32'(fefinish), 32'd0);
    expect_aligned('0, ctx);
  endtask

  // mode: 0 = ready always high, 1 = ready 1,0,1,0..., 2 = random ready plus stray back_done.
  // poke: pulse start mid-run with different arguments, which must be ignored.
  task automatic run(input logic [ADDR_W-1:0] base, input int nf, input int mode, input bit poke);
    slot_t prev;
    int    s;
    int    cyc;
    int    d;
    logic  rdy;
    next_cycle();
    start      = 1'b1;
    base_addr  = base;
    num_frames = CNT_W'(nf);
    ready      = 1'b1;
    back_done  = 1'b0;
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    check("load:busy",     32'(busy),     32'd1);
    check("load:ram_rd",   32'(ram_rd),   32'd0);
    check("load:framenum", 32'(framenum), 32'd0);
    prev = '0;
    for (int f = 0; f < nf; f++) begin
      s   = 0;
      cyc = 0;
      while (s < FFT) begin
        next_cycle();
        if (mode == 0)      rdy = 1'b1;
        else if (mode == 1) rdy = (cyc % 2 == 0);
        else                rdy = ($urandom_range(0, 99) < 60);
        ready     = rdy;
        back_done = (mode == 2) && ($urandom_range(0, 3) == 0);
        if (poke && f == nf - 1 && s == 2) begin
          start      = 1'b1;
          base_addr  = ~base;
          num_frames = 8'd200;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        expect_aligned(prev, "stream");
        check("stream:busy",     32'(busy),     32'd1);
        check("stream:framenum", 32'(framenum), 32'(f));
        check("stream:fefinish", 32'(fefinish), 32'd0);
        if (rdy) begin
          prev = slot_of(s);
          check("stream:ram_rd", 32'(ram_rd), 32'(prev.rd));
          if (prev.rd) check("stream:ram_addr", 32'(ram_addr), 32'(addr_of(base, f, s)));
          s++;
        end else begin
          prev = '0;
          check("stall:ram_rd", 32'(ram_rd), 32'd0);
          if (s < FL) check("stall:ram_addr", 32'(ram_addr), 32'(addr_of(base, f, s)));
        end
        cyc++;
        if (cyc > 1000) begin
          check("stream:timeout", 32'(cyc), 32'd0);
          start = 1'b0;
          return;
        end
      end
      d = $urandom_range(0, 3);
      for (int w = 0; w <= d; w++) begin
        next_cycle();
        start     = 1'b0;
        ready     = 1'b1;
        back_done = (w == d);
        @(negedge clk);
        expect_aligned(prev, "wait");
        prev = '0;
        check("wait:ram_rd",   32'(ram_rd),   32'd0);
        check("wait:busy",     32'(busy),     32'd1);
        check("wait:framenum", 32'(framenum), 32'(f));
        check("wait:fefinish", 32'(fefinish), 32'd0);
      end
    end
    next_cycle();
    back_done = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    expect_aligned(prev, "done");
    check("done:fefinish", 32'(fefinish), 32'd1);
    check("done:busy",     32'(busy),     32'd0);
    check("done:ram_rd",   32'(ram_rd),   32'd0);
    check("done:framenum", 32'(framenum), 32'((nf == 0) ? 0 : nf - 1));
    next_cycle();
    @(negedge clk);
    check("idle:fefinish", 32'(fefinish), 32'd0);
    check("idle:busy",     32'(busy),     32'd0);
    check("idle:framenum", 32'(framenum), 32'((nf == 0) ? 0 : nf - 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] ab;
    // Reset held with start asserted: reset must win.
    rst        = 1'b1;
    start      = 1'b1;
    ready      = 1'b0;
    back_done  = 1'b0;
    num_frames = 8'd1;
    base_addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_quiet("reset");

    run(15'd0, 1, 0, 1'b0);
    run(15'd100, 3, 0, 1'b1);
    run(15'd32764, 2, 1, 1'b0);
    run(15'd55, 0, 0, 1'b0);

    // Abort while streaming idx 5 of frame 0.
    ab = 15'd2000;
    next_cycle();
    start      = 1'b1;
    base_addr  = ab;
    num_frames = 8'd2;
    ready      = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (6) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("abort:pre_ram_rd",   32'(ram_rd),   32'd1);
    check("abort:pre_ram_addr", 32'(ram_addr), 32'(addr_of(ab, 0, 5)));
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    repeat (3) begin
      next_cycle();
      @(negedge clk);
      check("abort:no_fefinish", 32'(fefinish), 32'd0);
      check("abort:idle_busy",   32'(busy),     32'd0);
    end

    repeat (4) run(ADDR_W'($urandom), $urandom_range(1, 3), 2, 1'b0);
    run(15'd7, 1, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
